// File: rtl/instr_issue.sv
// rtl/instr_issue.sv - 4-entry instruction issue FIFO with RUN/HALTED control
// Optional issue counter enabled by defining ISSUE_CNT_EN.
module instr_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic [4:0]  opcode,
  output logic [1:0]  op_ext,
  output logic        issue_valid,
  input  logic        issue_ready,
  input  logic        halt_in,
  input  logic        flush,
  input  logic        resume,
  output logic        halted,
  output logic [15:0] issue_cnt
);

  localparam logic RUN    = 1'b0;
  localparam logic HALTED = 1'b1;

  logic [6:0] mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] count;
  logic       state;
  logic       full;
  logic       push;
  logic       pop;
  logic       unused_in_bits;

  // Only opcode and op_ext leave this block; the operand field is not stored.
  assign unused_in_bits = ^in_data[10:2];

  assign full        = (count == 3'd4);
  assign in_ready    = !full && !flush;
  assign issue_valid = (count != 3'd0) && (state == RUN) && !flush;
  assign push        = in_valid && in_ready;
  assign pop         = issue_valid && issue_ready;
  assign halted      = (state == HALTED);

  assign opcode = issue_valid ? mem[rd_ptr][6:2] : 5'd0;
  assign op_ext = issue_valid ? mem[rd_ptr][1:0] : 2'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_data[15:11], in_data[1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
      state  <= RUN;
    end else if (flush) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // A pop is only possible in RUN, so the two transitions never collide.
      if (state == RUN) begin
        if (pop && halt_in) begin
          state <= HALTED;
        end
      end else if (resume) begin
        state <= RUN;
      end
    end
  end

`ifdef ISSUE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else if (pop) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign issue_cnt = cnt_q;
`else
  assign issue_cnt = 16'd0;
`endif

endmodule
